// File: rtl/mem_resp.sv
// mem_resp: single-port word RAM behind a fixed-latency request/response
// handshake. Each access is busy for LATENCY cycles followed by one DONE
// cycle. During DONE, read data and the fault flag are valid, and any
// write is committed.
module mem_resp #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic        fetch,
    input  logic [1:0]  mem_sz,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_busy,
    output logic        mem_err
);

    localparam int unsigned Words = 1 << ADDR_W;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [1:0]          off_q;
    logic [1:0]          sz_q;
    logic [31:0]         wdata_q;
    logic                rd_q;
    logic                wr_q;
    logic                fetch_q;

    logic [31:0]         ram [Words];
    logic [31:0]         word;
    logic                req;
    logic                fault;
    logic [4:0]          byte_sh;
    logic [4:0]          half_sh;

    // Address bits above the RAM index alias onto the same words.
    logic unused_addr;
    assign unused_addr = ^mem_addr[31:ADDR_W+2];

    assign req     = mem_r | mem_w;
    assign word    = ram[idx_q];
    assign byte_sh = {off_q, 3'b000};
    assign half_sh = {off_q[1], 4'b0000};

    // Fault classification, evaluated on the latched request fields.
    always_comb begin
        fault = 1'b0;
        if (sz_q == 2'd1 && off_q[0])         fault = 1'b1;
        if (sz_q == 2'd2 && off_q != 2'd0)    fault = 1'b1;
        if (sz_q == 2'd3)                     fault = 1'b1;
        if (rd_q && wr_q)                     fault = 1'b1;
        if (fetch_q && wr_q)                  fault = 1'b1;
        if (fetch_q && sz_q != 2'd2)          fault = 1'b1;
    end

    // Handshake FSM: latch the request in IDLE, count down in WAIT, respond in DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        idx_q   <= mem_addr[ADDR_W+1:2];
                        off_q   <= mem_addr[1:0];
                        sz_q    <= mem_sz;
                        wdata_q <= mem_wdata;
                        rd_q    <= mem_r;
                        wr_q    <= mem_w;
                        fetch_q <= fetch;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? StDone : StWait;
                    end
                end
                StWait: begin
                    // Requester withdrew: abandon the access without a response.
                    if (!req) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Commit a write on the edge closing DONE; reset in DONE cancels it.
    always_ff @(posedge clk) begin
        if (rst && state_q == StDone && wr_q && !fault) begin
            unique case (sz_q)
                2'd0:    ram[idx_q][byte_sh +: 8]  <= wdata_q[7:0];
                2'd1:    ram[idx_q][half_sh +: 16] <= wdata_q[15:0];
                default: ram[idx_q]                <= wdata_q;
            endcase
        end
    end

    // Response outputs: data and error only during a live DONE cycle.
    always_comb begin
        mem_rdata = '0;
        mem_err   = 1'b0;
        mem_busy  = 1'b0;
        if (rst) begin
            mem_busy = (state_q == StIdle && req) || (state_q == StWait);
            if (state_q == StDone) begin
                mem_err = fault;
                if (!fault) begin
                    unique case (sz_q)
                        2'd0:    mem_rdata = {24'b0, word[byte_sh +: 8]};
                        2'd1:    mem_rdata = {16'b0, word[half_sh +: 16]};
                        default: mem_rdata = word;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed and randomized accesses checked against a
// byte-addressed reference memory kept in the bench.
module tb_mem_resp;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned MASK    = (4 << ADDR_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r, mem_w, fetch;
    logic [1:0]  mem_sz;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy, mem_err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] bmem [int unsigned];

    mem_resp #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_r     (mem_r),
        .mem_w     (mem_w),
        .fetch     (fetch),
        .mem_sz    (mem_sz),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_fault(input logic r, input logic w, input logic f,
                                         input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || sz == 2'd3 ||
               (r && w) || (f && w) || (f && sz != 2'd2);
    endfunction

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] v = '0;
        for (int i = 0; i < int'(nbytes(sz)); i++) begin
            v[8*i +: 8] = bmem[(a + i) & MASK];
        end
        return v;
    endfunction

    task automatic model_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < int'(nbytes(sz)); i++) begin
            bmem[(a + i) & MASK] = d[8*i +: 8];
        end
    endtask

    // mode 0: plain; 1: disturb address/size/data after acceptance; 2: drop request in WAIT.
    task automatic access(input logic r, input logic w, input logic f, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wdata, input int mode,
                          input logic [31:0] alt_addr, output logic [31:0] rd);
        int   busy_n = 0;
        bit   done = 0;
        logic exp_fault = model_fault(r, w, f, sz, addr);
        logic [31:0] exp_rd = (exp_fault || mode == 2) ? 32'h0 : model_read(sz, addr);
        @(negedge clk);
        mem_r = r; mem_w = w; fetch = f; mem_sz = sz; mem_addr = addr; mem_wdata = wdata;
        for (int c = 0; c < 20 && !done; c++) begin
            #2;
            if (mem_busy) begin
                busy_n++;
                check("busy_rdata_zero", mem_rdata, 32'h0);
                check("busy_err_zero", {31'b0, mem_err}, 32'h0);
                @(negedge clk);
                if (mode == 1 && busy_n == 1) begin
                    mem_addr = alt_addr; mem_sz = ~sz; mem_wdata = ~wdata;
                end
                if (mode == 2 && busy_n == 1) begin
                    mem_r = 1'b0; mem_w = 1'b0;
                end
            end else begin
                done = 1;
            end
        end
        if (!done) check("timeout", 32'h0, 32'h1);
        rd = mem_rdata;
        check("busy_cycles", busy_n, LATENCY);
        check("err", {31'b0, mem_err}, (mode == 2) ? 32'h0 : {31'b0, exp_fault});
        if (r || exp_fault || mode == 2) check("rdata", mem_rdata, exp_rd);
        if (w && !exp_fault && mode != 2) model_write(sz, addr, wdata);
        mem_r = 1'b0; mem_w = 1'b0; fetch = 1'b0;
        @(negedge clk);
        #2;
        check("err_pulse_end", {31'b0, mem_err}, 32'h0);
        check("idle_rdata_zero", mem_rdata, 32'h0);
    endtask

    logic [31:0] rd;

    initial begin
        rst = 1'b0; mem_r = 1'b1; mem_w = 1'b0; fetch = 1'b0;
        mem_sz = 2'd2; mem_addr = 32'h0; mem_wdata = 32'h0;
        @(negedge clk); @(negedge clk);
        #2;
        check("rst_busy", {31'b0, mem_busy}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_err", {31'b0, mem_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1; mem_r = 1'b0;

        // Word write then read back.
        access(0, 1, 0, 2'd2, 32'h100, 32'hDEADBEEF, 0, 0, rd);
        access(1, 0, 0, 2'd2, 32'h100, 32'h0, 0, 0, rd);
        check("word_rd", rd, 32'hDEADBEEF);

        // Lane-selective byte write, half and byte reads.
        access(0, 1, 0, 2'd2, 32'h200, 32'h11223344, 0, 0, rd);
        access(0, 1, 0, 2'd0, 32'h201, 32'hFFFFFFAA, 0, 0, rd);
        access(1, 0, 0, 2'd1, 32'h202, 32'h0, 0, 0, rd);
        check("half_rd", rd, 32'h00001122);
        access(1, 0, 0, 2'd0, 32'h201, 32'h0, 0, 0, rd);
        check("byte_rd", rd, 32'h000000AA);
        access(1, 0, 0, 2'd2, 32'h200, 32'h0, 0, 0, rd);
        check("merged_rd", rd, 32'h1122AA44);

        // Faults, then verify the RAM is untouched.
        access(0, 1, 0, 2'd2, 32'h300, 32'h01020304, 0, 0, rd);
        access(1, 0, 0, 2'd2, 32'h103, 32'h0, 0, 0, rd);
        access(0, 1, 0, 2'd1, 32'h301, 32'hFFFFFFFF, 0, 0, rd);
        access(0, 1, 1, 2'd2, 32'h300, 32'hFFFFFFFF, 0, 0, rd);
        access(0, 1, 0, 2'd3, 32'h300, 32'hFFFFFFFF, 0, 0, rd);
        access(1, 0, 0, 2'd2, 32'h300, 32'h0, 0, 0, rd);
        check("fault_no_write", rd, 32'h01020304);

        // Inputs changing in WAIT are ignored; dropping the request aborts.
        access(0, 1, 0, 2'd2, 32'h500, 32'hAAAA5555, 0, 0, rd);
        access(0, 1, 0, 2'd2, 32'h504, 32'h12345678, 0, 0, rd);
        access(1, 0, 0, 2'd2, 32'h500, 32'h0, 1, 32'h504, rd);
        check("latched_addr", rd, 32'hAAAA5555);
        access(0, 1, 0, 2'd2, 32'h500, 32'h99999999, 2, 0, rd);
        access(1, 0, 0, 2'd2, 32'h500, 32'h0, 0, 0, rd);
        check("abort_no_write", rd, 32'hAAAA5555);

        // Reset in DONE cancels the pending write.
        access(0, 1, 0, 2'd2, 32'h400, 32'h0, 0, 0, rd);
        @(negedge clk);
        mem_w = 1'b1; mem_sz = 2'd0; mem_addr = 32'h400; mem_wdata = 32'h55;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("done_busy_low", {31'b0, mem_busy}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_done_err", {31'b0, mem_err}, 32'h0);
        check("rst_done_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1; mem_w = 1'b0;
        access(1, 0, 0, 2'd2, 32'h400, 32'h0, 0, 0, rd);
        check("rst_cancel", rd, 32'h00000000);

        // Upper address bits alias.
        access(0, 1, 0, 2'd2, 32'h00010000, 32'hCAFEF00D, 0, 0, rd);
        access(1, 0, 0, 2'd2, 32'h00000000, 32'h0, 0, 0, rd);
        check("alias", rd, 32'hCAFEF00D);

        // Randomized traffic over an initialized window.
        for (int i = 0; i < 16; i++) begin
            access(0, 1, 0, 2'd2, 32'h600 + 4 * i, $urandom, 0, 0, rd);
        end
        for (int i = 0; i < 60; i++) begin
            logic r, w, f;
            r = 1'($urandom_range(0, 1));
            w = !r;
            if ($urandom_range(0, 15) == 0) begin r = 1'b1; w = 1'b1; end
            f = ($urandom_range(0, 7) == 0);
            access(r, w, f, 2'($urandom_range(0, 3)), 32'h600 + $urandom_range(0, 63),
                   $urandom, 0, 0, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
